// File: rtl/contador_garrafas_pkg.sv
// Shared constants and FSM encoding for the contador_garrafas bottle counter.
package contador_garrafas_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    SINALIZA  = 2'd1,
    INTERVALO = 2'd2
  } estado_t;

  localparam int GARRAFAS_POR_DUZIA_PADRAO = 12;
  localparam int LARGURA_PARCIAL           = 4;

endpackage

// File: rtl/contador_garrafas_filtro_sensor.sv
// Final-sensor conditioning: 2-FF synchroniser, optional debounce (SENSOR_FILTRO_EN)
// and registered rising-edge detector producing a 1-cycle pulso_garrafa.
module filtro_sensor #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_in,
  output logic pulso_garrafa
);

  logic [1:0] sinc_q, sinc_d;
  logic       nivel;
  logic       nivel_ant_q, nivel_ant_d;
  logic       pulso_q, pulso_d;

  // Empty scope marks an out-of-range setting in the elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_invalido
  end

`ifdef SENSOR_FILTRO_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] corrida_q, corrida_d;
  logic          nivel_q, nivel_d;

  // The run counter restarts whenever the synced sample agrees with the accepted level.
  always_comb begin
    corrida_d = '0;
    nivel_d   = nivel_q;
    if (sinc_q[1] != nivel_q) begin
      if (corrida_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        nivel_d = sinc_q[1];
      end else begin
        corrida_d = corrida_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corrida_q <= '0;
      nivel_q   <= 1'b0;
    end else begin
      corrida_q <= corrida_d;
      nivel_q   <= nivel_d;
    end
  end

  assign nivel = nivel_q;
`else
  assign nivel = sinc_q[1];
`endif

  always_comb begin
    sinc_d      = {sinc_q[0], sensor_in};
    nivel_ant_d = nivel;
    pulso_d     = nivel & ~nivel_ant_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc_q      <= '0;
      nivel_ant_q <= 1'b0;
      pulso_q     <= 1'b0;
    end else begin
      sinc_q      <= sinc_d;
      nivel_ant_q <= nivel_ant_d;
      pulso_q     <= pulso_d;
    end
  end

  assign pulso_garrafa = pulso_q;

endmodule

// File: rtl/contador_garrafas.sv
// Bottle counter: counts accepted bottles modulo GARRAFAS_POR_DUZIA and shapes the
// dozen-complete pulse. Debounce filter is built only when SENSOR_FILTRO_EN is defined.
module contador_garrafas
  import contador_garrafas_pkg::*;
#(
  parameter int GARRAFAS_POR_DUZIA = GARRAFAS_POR_DUZIA_PADRAO,
  parameter int DEBOUNCE_CYCLES    = 1000,
  parameter int PULSO_CICLOS       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sensor_final,
  input  logic                       habilitar,
  input  logic                       reset_manual,
  output logic                       duzia_completa,
  output logic [LARGURA_PARCIAL-1:0] garrafas_parcial,
  output logic                       erro_overflow
);

  localparam int PW = (PULSO_CICLOS > 1) ? $clog2(PULSO_CICLOS) : 1;

  logic                       pulso_garrafa;
  logic [LARGURA_PARCIAL-1:0] parcial_q, parcial_d;
  logic                       evento_q, evento_d;
  estado_t                    estado_q, estado_d;
  logic [PW-1:0]              cnt_q, cnt_d;
  logic                       pendente_q, pendente_d;
  logic                       erro_q, erro_d;
  logic                       duzia_q, duzia_d;

  filtro_sensor #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filtro (
    .clk          (clk),
    .reset        (reset),
    .sensor_in    (sensor_final),
    .pulso_garrafa(pulso_garrafa)
  );

  always_comb begin
    parcial_d  = parcial_q;
    evento_d   = 1'b0;
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    pendente_d = pendente_q;
    erro_d     = erro_q;

    if (pulso_garrafa && habilitar) begin
      if (parcial_q == LARGURA_PARCIAL'(GARRAFAS_POR_DUZIA - 1)) begin
        parcial_d = '0;
        evento_d  = 1'b1;
      end else begin
        parcial_d = parcial_q + 1'b1;
      end
    end

    case (estado_q)
      OCIOSO: begin
        if (evento_q || pendente_q) begin
          estado_d = SINALIZA;
          cnt_d    = '0;
          if (!evento_q) pendente_d = 1'b0;
        end
      end
      SINALIZA: begin
        if (cnt_q == PW'(PULSO_CICLOS - 1)) estado_d = INTERVALO;
        else                                cnt_d    = cnt_q + 1'b1;
      end
      INTERVALO: begin
        if (pendente_q) begin
          estado_d   = SINALIZA;
          cnt_d      = '0;
          pendente_d = 1'b0;
        end else begin
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // A dozen arriving while the pulse is busy is queued once; a second one is lost.
    if (evento_q && (estado_q != OCIOSO)) begin
      if (pendente_q) erro_d     = 1'b1;
      else            pendente_d = 1'b1;
    end

    if (reset_manual) begin
      parcial_d  = '0;
      evento_d   = 1'b0;
      estado_d   = OCIOSO;
      cnt_d      = '0;
      pendente_d = 1'b0;
      erro_d     = 1'b0;
    end

    duzia_d = (estado_d == SINALIZA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parcial_q  <= '0;
      evento_q   <= 1'b0;
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      pendente_q <= 1'b0;
      erro_q     <= 1'b0;
      duzia_q    <= 1'b0;
    end else begin
      parcial_q  <= parcial_d;
      evento_q   <= evento_d;
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      pendente_q <= pendente_d;
      erro_q     <= erro_d;
      duzia_q    <= duzia_d;
    end
  end

  assign duzia_completa   = duzia_q;
  assign garrafas_parcial = parcial_q;
  assign erro_overflow    = erro_q;

endmodule

// File: tb/tb_contador_garrafas.sv
// Scoreboard bench for contador_garrafas: two instances (nominal and fast/overflow setup).
module tb_contador_garrafas;

  localparam int DEB = 20, HI = 60, LO = 60, GLITCH = 10;
  localparam int N1 = 12, P1 = 4, N2 = 2, P2 = 40;
`ifdef SENSOR_FILTRO_EN
  localparam int LAT_ESP = DEB + 4;
`else
  localparam int LAT_ESP = 4;
`endif

  typedef struct packed {int len; int gap; int ofs;} pulso_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s1 = 1'b0, h1 = 1'b1, rm1 = 1'b0, d1, e1;
  logic       s2 = 1'b0, h2 = 1'b1, rm2 = 1'b0, d2, e2;
  logic [3:0] g1, g2;

  always #5 clk = ~clk;

  contador_garrafas #(
    .GARRAFAS_POR_DUZIA(N1), .DEBOUNCE_CYCLES(DEB), .PULSO_CICLOS(P1)
  ) dut (
    .clk(clk), .reset(rst_n), .sensor_final(s1), .habilitar(h1), .reset_manual(rm1),
    .duzia_completa(d1), .garrafas_parcial(g1), .erro_overflow(e1)
  );

  contador_garrafas #(
    .GARRAFAS_POR_DUZIA(N2), .DEBOUNCE_CYCLES(1), .PULSO_CICLOS(P2)
  ) dut2 (
    .clk(clk), .reset(rst_n), .sensor_final(s2), .habilitar(h2), .reset_manual(rm2),
    .duzia_completa(d2), .garrafas_parcial(g2), .erro_overflow(e2)
  );

  int     n_chk = 0, n_fail = 0;
  int     cq [2][$];
  int     eq [2][$];
  pulso_t pq [2][$];
  int     modelo [2];
  bit     erro_mod [2];

  task automatic check(input string nome, input int atual, input int esperado);
    n_chk++;
    if (atual != esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic inesperado(input string nome, input int atual);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d, expected no event (t=%0t)", nome, atual, $time);
  endtask

  // Monitor: every change of a DUT output consumes one scoreboard entry.
  int cyc = 0;
  int prev_g [2], prev_d [2], prev_e [2], len [2], gap [2], wrap [2], r_gap [2], r_ofs [2];
  bit em_pulso [2];
  int nmax [2] = '{N1, N2};

  always @(negedge clk) begin
    int g [2];
    int d [2];
    int e [2];
    pulso_t p;
    cyc++;
    g[0] = int'(g1); g[1] = int'(g2);
    d[0] = int'(d1); d[1] = int'(d2);
    e[0] = int'(e1); e[1] = int'(e2);
    for (int i = 0; i < 2; i++) begin
      if (g[i] != prev_g[i]) begin
        if (cq[i].size() == 0) inesperado($sformatf("parcial%0d", i), g[i]);
        else                   check($sformatf("parcial%0d", i), g[i], cq[i].pop_front());
        if (g[i] == 0 && prev_g[i] == nmax[i] - 1) wrap[i] = cyc;
      end
      if (e[i] != prev_e[i]) begin
        if (eq[i].size() == 0) inesperado($sformatf("erro%0d", i), e[i]);
        else                   check($sformatf("erro%0d", i), e[i], eq[i].pop_front());
      end
      if (!rst_n) begin
        em_pulso[i] = 1'b0;
        gap[i]      = 1000;
      end else if (d[i] == 1 && prev_d[i] == 0) begin
        em_pulso[i] = 1'b1;
        len[i]      = 1;
        r_gap[i]    = gap[i];
        r_ofs[i]    = cyc - wrap[i];
      end else if (d[i] == 1) begin
        len[i]++;
      end else if (prev_d[i] == 1 && em_pulso[i]) begin
        em_pulso[i] = 1'b0;
        gap[i]      = 1;
        if (pq[i].size() == 0) inesperado($sformatf("pulso%0d", i), len[i]);
        else begin
          p = pq[i].pop_front();
          check($sformatf("pulso%0d_largura", i), len[i], p.len);
          if (p.gap >= 0) check($sformatf("pulso%0d_intervalo", i), r_gap[i], p.gap);
          if (p.ofs >= 0) check($sformatf("pulso%0d_atraso", i), r_ofs[i], p.ofs);
        end
      end else if (gap[i] < 1000) begin
        gap[i]++;
      end
      prev_g[i] = g[i];
      prev_d[i] = d[i];
      prev_e[i] = e[i];
    end
  end

  task automatic espera(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic garrafa1(input int hi, input int lo, input bit medir);
    int lat;
    logic [3:0] g_antes;
    if (h1) begin
      modelo[0] = (modelo[0] + 1) % N1;
      cq[0].push_back(modelo[0]);
      if (modelo[0] == 0) pq[0].push_back(pulso_t'{P1, -1, 1});
    end
    g_antes = g1;
    s1 = 1'b1;
    if (medir) begin
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
        @(posedge clk); #1;
        if (g1 != g_antes) begin
          lat = i;
          break;
        end
      end
      check("latencia", lat, LAT_ESP);
      if (hi > lat) espera(hi - lat);
    end else begin
      espera(hi);
    end
    s1 = 1'b0;
    espera(lo);
  endtask

  task automatic glitch1();
`ifndef SENSOR_FILTRO_EN
    modelo[0] = (modelo[0] + 1) % N1;
    cq[0].push_back(modelo[0]);
`endif
    s1 = 1'b1;
    espera(GLITCH);
    s1 = 1'b0;
    espera(LO);
  endtask

  task automatic manual1();
    if (modelo[0] != 0) cq[0].push_back(0);
    modelo[0] = 0;
    rm1 = 1'b1;
    espera(1);
    rm1 = 1'b0;
  endtask

  task automatic garrafa2();
    modelo[1] = (modelo[1] + 1) % N2;
    cq[1].push_back(modelo[1]);
    s2 = 1'b1;
    espera(3);
    s2 = 1'b0;
    espera(3);
  endtask

  task automatic manual2();
    if (modelo[1] != 0) cq[1].push_back(0);
    if (erro_mod[1]) eq[1].push_back(0);
    modelo[1]   = 0;
    erro_mod[1] = 1'b0;
    rm2 = 1'b1;
    espera(1);
    rm2 = 1'b0;
  endtask

  initial begin
    espera(2);
    check("reset_parcial1", int'(g1), 0);
    check("reset_duzia1", int'(d1), 0);
    check("reset_erro1", int'(e1), 0);
    check("reset_parcial2", int'(g2), 0);
    check("reset_duzia2", int'(d2), 0);
    check("reset_erro2", int'(e2), 0);
    rst_n = 1'b1;
    espera(5);

    // Twelve clean bottles: 1..11, wrap to 0, one 4-cycle pulse one cycle after the wrap.
    garrafa1(HI, LO, 1'b1);
    repeat (11) garrafa1(HI, LO, 1'b0);
    espera(20);

    // Eleven bottles, manual clear, one more bottle; no dozen pulse.
    repeat (11) garrafa1(HI, LO, 1'b0);
    manual1();
    garrafa1(HI, LO, 1'b0);
    manual1();

    // Short glitches: rejected by the filter, counted without it.
    repeat (3) glitch1();
    manual1();

    // Disabled conveyor drops edges; then a full dozen.
    h1 = 1'b0;
    repeat (3) garrafa1(HI, LO, 1'b0);
    h1 = 1'b1;
    repeat (12) garrafa1(HI, LO, 1'b0);
    espera(20);

    // Fast instance: pulse, queued dozen after a 1-cycle gap, third dozen overflows.
    pq[1].push_back(pulso_t'{P2, -1, 1});
    pq[1].push_back(pulso_t'{P2, 1, -1});
    eq[1].push_back(1);
    erro_mod[1] = 1'b1;
    repeat (6) garrafa2();
    espera(100);
    check("erro_pegajoso", int'(e2), 1);
    manual2();
    espera(5);

    // Asynchronous reset in the middle of a pulse.
    garrafa2();
    garrafa2();
    garrafa2();
    check("pulso_em_curso", int'(d2), 1);
    cq[1].push_back(0);
    modelo[1] = 0;
    rst_n = 1'b0;
    #1;
    check("reset_async_duzia2", int'(d2), 0);
    check("reset_async_parcial2", int'(g2), 0);
    check("reset_async_duzia1", int'(d1), 0);
    espera(3);
    rst_n = 1'b1;
    espera(2);
    pq[1].push_back(pulso_t'{P2, -1, 1});
    garrafa2();
    garrafa2();
    espera(60);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("fila_parcial%0d_restante", i), cq[i].size(), 0);
      check($sformatf("fila_erro%0d_restante", i), eq[i].size(), 0);
      check($sformatf("fila_pulso%0d_restante", i), pq[i].size(), 0);
      check($sformatf("pulso%0d_aberto", i), int'(em_pulso[i]), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_garrafas.md
Name: contador_garrafas

Overview:
- Bottle-level counter feeding the dozen counter.
- Conditions the raw final-position sensor, counts approved bottles 0..11 and, on every 12th bottle, drives a dozen-complete pulse.
- The pulse is shaped so the dozen counter's rising-edge detector registers exactly one increment per dozen.
- Sits between the final sensor input pin and the dozen counter's increment input.

Parameters:
- GARRAFAS_POR_DUZIA, 12: bottles per dozen. Legal range 2..15.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required before a sensor level is accepted. Must be ≥1.
- PULSO_CICLOS, 4: cycles duzia_completa is held high. Must be ≥1.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-low global reset (0 = reset).
- sensor_final  in  1  raw, asynchronous final-position sensor, high while a bottle is present.
- habilitar  in  1  conveyor running; sensor edges are ignored while low.
- reset_manual  in  1  one-cycle pulse from START; clears the partial count.
- duzia_completa  out  1  dozen-complete pulse toward the dozen counter.
- garrafas_parcial  out  4  bottles in the current dozen, 0..GARRAFAS_POR_DUZIA-1.
- erro_overflow  out  1  sticky: a dozen was lost because a second one was pending.

Behaviour:
- Reset (reset=0), asynchronous:
  - duzia_completa=0, garrafas_parcial=0, erro_overflow=0.
  - Synchroniser/filter state 0, pendente=0, FSM=OCIOSO.
- Input path:
  - sensor_final passes through a 2-FF synchroniser, then the debounce filter (when SENSOR_FILTRO_EN is defined), then a rising-edge detector.
  - Filter: the accepted level changes only after DEBOUNCE_CYCLES consecutive synced samples at the new level. A shorter glitch leaves the accepted level unchanged and restarts the run count.
- Counting:
  - On an accepted rising edge with habilitar=1, garrafas_parcial increments.
  - When garrafas_parcial = GARRAFAS_POR_DUZIA-1 at that edge, it wraps to 0 and a dozen event is raised in the same cycle.
- Latency:
  - With the filter: sensor high first sampled at edge k → garrafas_parcial updated at edge k+3+DEBOUNCE_CYCLES.
  - Without the filter: updated at edge k+3.
- Output FSM, 2-bit:
  - OCIOSO: duzia_completa=0. A dozen event (or pendente=1) → SINALIZA.
  - SINALIZA: duzia_completa=1 for exactly PULSO_CICLOS cycles, then → INTERVALO.
  - INTERVALO: duzia_completa=0 for exactly 1 cycle, then → OCIOSO, or straight to SINALIZA if pendente=1 (clearing pendente).
  - duzia_completa rises on the edge after the dozen event (1-cycle latency) and is registered, glitch-free.
- Dozen event while in SINALIZA/INTERVALO:
  - If pendente=0, set pendente=1.
  - If pendente=1 already, drop the event and set erro_overflow=1.
- Counting continues independently of FSM state.
- reset_manual=1 (priority over everything except reset):
  - Next edge: garrafas_parcial=0, pendente=0, FSM=OCIOSO, duzia_completa=0 (aborts an in-flight pulse), erro_overflow=0.
  - A sensor edge in the same cycle is discarded.
- habilitar=0:
  - Edges are discarded, not deferred.
  - An in-flight pulse and a pending dozen still complete.
  - garrafas_parcial holds its value.
- Sensor held high indefinitely counts one bottle only; a new bottle requires an accepted low then high.

Optional Feature:
- Macro: SENSOR_FILTRO_EN.
- Defined: the debounce filter is instantiated, with latency as above.
- Undefined: the synchroniser output feeds the edge detector directly, DEBOUNCE_CYCLES is unused, and glitches ≥1 cycle are counted.

Decomposition:
- Shared package/include holds:
  - FSM state encodings OCIOSO=2'd0, SINALIZA=2'd1, INTERVALO=2'd2.
  - Default GARRAFAS_POR_DUZIA.
  - Width constant for garrafas_parcial (4).
- One sub-module, filtro_sensor: synchroniser, optional debounce and rising-edge detector, emitting a 1-cycle pulso_garrafa.

Test Plan:
- Reset, then 12 clean sensor pulses (high 2000 cycles, low 2000, habilitar=1, DEBOUNCE_CYCLES=1000):
  - garrafas_parcial steps 1..11 then 0.
  - duzia_completa high exactly 4 cycles, starting 1 cycle after the wrap.
- 11 bottles, then reset_manual pulse, then 1 bottle:
  - garrafas_parcial=0 after reset_manual, then 1.
  - No duzia_completa.
- Glitches of 500 cycles on sensor_final (filter enabled):
  - No count change.
  - The same stimulus with SENSOR_FILTRO_EN undefined counts every glitch.
- habilitar=0 during 3 bottle pulses, then habilitar=1 for 12:
  - Only the last 12 counted.
  - Exactly one duzia_completa pulse.
- GARRAFAS_POR_DUZIA=2, PULSO_CICLOS=40, DEBOUNCE_CYCLES=1, rapid bottles:
  - 2nd dozen during SINALIZA → pulse, 1-cycle low, pulse.
  - 3rd dozen while pending → erro_overflow=1, sticky until reset_manual.
- reset asserted mid-pulse:
  - duzia_completa=0 and garrafas_parcial=0 immediately (asynchronous).
  - Counting resumes normally after release.
